pipe_hazard_unit: RTL

//  Hazard/sequencing controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB) that replaces the single-cycle datapath.

---
 rtl/core_pkg.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared pipeline definitions: register-index width, forward-select codes,
// and the shadow entry tracked for each of EX/MEM/WB.
package core_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_DEF-1:0] rd;
      logic [REG_AW_DEF-1:0] rs1;
      logic [REG_AW_DEF-1:0] rs2;
      logic                  reg_write;
      logic                  mem_read;
   } shadow_t;

   // x0 is hardwired, so an entry targeting it never produces a hazard.
   function automatic logic is_writer(shadow_t e);
      return e.valid && e.reg_write && (e.rd != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EX operand: the younger MEM writer wins over WB.
module hazard_fwd_sel
   import core_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              mem_wr,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_wr,
   input  logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_RF;
      if (mem_wr && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_wr && (wb_rd == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/sequencing controller: shadows EX/MEM/WB, issues stall/flush/bubble
// controls and forward selects, and keeps retire/stall/flush counters.
module pipe_hazard_unit
   import core_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF,
   parameter int unsigned CNT_W  = 32,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              start,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regWrite,
   input  logic              id_memRead,
   input  logic              ex_branch_taken,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              wb_byp_a,
   output logic              wb_byp_b,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   shadow_t    ex_q, mem_q, wb_q, id_ent;
   logic       ex_wr, mem_wr, wb_wr;
   logic       ex_hit, mem_hit, load_use, raw_stall, stall;
   logic [1:0] sel_a, sel_b;
   logic       unused_fields;

   assign id_ent = '{valid: 1'b1, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                     reg_write: id_regWrite, mem_read: id_memRead};

   assign ex_wr  = is_writer(ex_q);
   assign mem_wr = is_writer(mem_q);
   assign wb_wr  = is_writer(wb_q);

   assign ex_hit  = ex_wr && ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                              (id_use_rs2 && (id_rs2 == ex_q.rd)));
   assign mem_hit = mem_wr && ((id_use_rs1 && (id_rs1 == mem_q.rd)) ||
                               (id_use_rs2 && (id_rs2 == mem_q.rd)));

   // With forwarding only a load in EX is unresolvable; without it, any
   // EX/MEM producer blocks ID until it reaches WB (covered by wb_byp).
   assign load_use  = FWD_EN && id_valid && ex_hit && ex_q.mem_read;
   assign raw_stall = !FWD_EN && id_valid && (ex_hit || mem_hit);
   assign stall     = load_use || raw_stall;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
      .rs     (ex_q.rs1),
      .mem_wr (mem_wr),
      .mem_rd (mem_q.rd),
      .wb_wr  (wb_wr),
      .wb_rd  (wb_q.rd),
      .sel    (sel_a)
   );

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
      .rs     (ex_q.rs2),
      .mem_wr (mem_wr),
      .mem_rd (mem_q.rd),
      .wb_wr  (wb_wr),
      .wb_rd  (wb_q.rd),
      .sel    (sel_b)
   );

   assign fwd_a = FWD_EN ? sel_a : FWD_RF;
   assign fwd_b = FWD_EN ? sel_b : FWD_RF;

   assign wb_byp_a = wb_wr && id_use_rs1 && (wb_q.rd == id_rs1);
   assign wb_byp_b = wb_wr && id_use_rs2 && (wb_q.rd == id_rs2);

   assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.mem_read,
                            wb_q.rs1, wb_q.rs2, wb_q.mem_read};

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         retired_cnt <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         wb_q        <= mem_q;
         mem_q       <= ex_q;
         ex_q        <= (id_valid && !idex_bubble) ? id_ent : '0;
         retired_cnt <= retired_cnt + CNT_W'(wb_q.valid);
         stall_cnt   <= stall_cnt + CNT_W'(!pc_en);
         flush_cnt   <= flush_cnt + CNT_W'(ex_branch_taken);
      end
   end

endmodule
